bram_pattern_writer: RTL
========================

// Module: bram_pattern_writer
// PURPOSE
//  Upstream write-side stage for the 256x16 implicit block RAM read by the VGA scan-out path.
//  On each start pulse it fills every BRAM entry with a generated 3-bit RGB pattern, one entry per clock.
//  The scan-out path reads data[2:0] as {R,G,B}.
//  The top level fires start from the vertical-blank edge, so the buffer is refreshed once per frame.
//  A per-frame offset animates the scrolling pattern.
// PARAMETERS
//  ADDR_BITS   8   BRAM address width; DEPTH = 2**ADDR_BITS entries
//  DATA_BITS   16  BRAM data width; bits [DATA_BITS-1:3] always written 0
//  SCROLL_STEP 1   added to offset after each completed fill (mod 2**ADDR_BITS)
// PORTS
//  CLK          in   1          system clock (12 MHz)
//  rst          in   1          synchronous, active-high reset
//  start        in   1          one-cycle request to begin a fill; sampled only in IDLE
//  pattern_sel  in   2          0 solid, 1 colour bars, 2 checker, 3 scrolling bars
//  solid_color  in   3          {R,G,B} used by pattern 0
//  w_en         out  1          BRAM write enable
//  w_addr       out  ADDR_BITS  BRAM write address
//  w_data       out  DATA_BITS  BRAM write data
//  busy         out  1          high while a fill is in progress
//  done         out  1          one-cycle pulse after the last entry is written
//  frame_offset out  ADDR_BITS  current scroll offset
// BEHAVIOUR
//  Reset values (all outputs registered):
//   - w_en=0, w_addr=0, w_data=0, busy=0, done=0, frame_offset=0
//   - FSM=IDLE; latched sel/color = 0
//  FSM states: IDLE, WRITE, DONE.
//   - IDLE: on start=1, go to WRITE.
//     Latch pattern_sel, solid_color and frame_offset into internal regs on the same edge.
//   - WRITE: w_en=1, busy=1.
//     w_addr counts 0..DEPTH-1, one per cycle; w_data is the pattern for the current w_addr.
//     When w_addr==DEPTH-1, go to DONE.
//   - DONE: for one cycle, w_en=0, busy=0, done=1.
//     frame_offset <= frame_offset+SCROLL_STEP (wraps); then go to IDLE.
//  Latency, with start sampled on edge N:
//   - first write (addr 0) is presented during cycle N+1
//   - last write (addr DEPTH-1) is presented during cycle N+DEPTH
//   - done is high during cycle N+DEPTH+1
//   - earliest accepted restart: edge N+DEPTH+2
//  Pattern, a = w_addr, off = latched offset, w_data[2:0]:
//   - 0: solid_color (latched)
//   - 1: a[ADDR_BITS-1 -: 3]  (8 equal bars)
//   - 2: a[3] ? 3'b111 : 3'b000
//   - 3: (a+off)[ADDR_BITS-1 -: 3], sum mod 2**ADDR_BITS
//  Input timing rules:
//   - start while busy or in DONE is ignored; no queuing.
//   - pattern_sel/solid_color changes mid-fill have no effect until the next start.
//  w_addr holds its last value when w_en=0; write-side consumers must qualify on w_en.
//  Reset mid-fill: on the next edge all outputs return to reset values and FSM=IDLE.
//   - The partial fill is abandoned.
//   - frame_offset returns to 0 (not advanced).
//  start and rst high together: rst wins.
// TESTING
//  1 Reset, start@N, sel=1 -> w_en high N+1..N+256; addr 0->31 data 0, addr 224->255 data 7; done@N+257
//  2 sel=0, color=3'b101, start; change color to 3'b010 mid-fill -> all 256 writes = 16'h0005
//  3 sel=3, 3 back-to-back fills -> offset 0,1,2; fill#2 addr 255 data=((255+1)%256)>>5 = 0
//  4 start pulsed again at cycle N+100 -> ignored; exactly 256 writes; single done pulse
//  5 rst at cycle N+50 -> next cycle w_en=0, busy=0, offset=0; new start refills from addr 0
//  6 sel=2 -> addr 0-7 data 0, addr 8-15 data 7, repeating; bits[15:3] always 0

Source files
------------

// File: rtl/bram_pattern_writer.sv
// Fills every entry of the scan-out BRAM with a generated 3-bit RGB pattern, one entry per clock,
// each time a start pulse is accepted. The scroll offset advances once per completed fill.
module bram_pattern_writer #(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_BITS   = 16,
  parameter int SCROLL_STEP = 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           pattern_sel,
  input  logic [2:0]           solid_color,
  output logic                 w_en,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic [DATA_BITS-1:0] w_data,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_BITS-1:0] frame_offset,
  output logic [1:0]           dbg_state
);

  // Write port: a BRAM entry is written on every clock where w_en=1; there is no back-pressure,
  // and w_addr/w_data carry no meaning while w_en=0.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [ADDR_BITS-1:0] ADDR_ONE = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] STEP     = ADDR_BITS'(SCROLL_STEP);

  state_t               state_q, state_d;
  logic                 w_en_q, w_en_d;
  logic [ADDR_BITS-1:0] w_addr_q, w_addr_d;
  logic [DATA_BITS-1:0] w_data_q, w_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ADDR_BITS-1:0] offset_q, offset_d;
  logic [1:0]           sel_q, sel_d;
  logic [2:0]           color_q, color_d;
  logic [ADDR_BITS-1:0] fill_off_q, fill_off_d;

  function automatic logic [DATA_BITS-1:0] pattern_word(
    input logic [1:0]           sel,
    input logic [2:0]           color,
    input logic [ADDR_BITS-1:0] a,
    input logic [ADDR_BITS-1:0] off
  );
    logic [ADDR_BITS-1:0] sum;
    logic [2:0]           rgb;
    sum = a + off;
    case (sel)
      2'd0:    rgb = color;
      2'd1:    rgb = a[ADDR_BITS-1 -: 3];
      2'd2:    rgb = a[3] ? 3'b111 : 3'b000;
      default: rgb = sum[ADDR_BITS-1 -: 3];
    endcase
    return {{(DATA_BITS-3){1'b0}}, rgb};
  endfunction

  always_comb begin
    state_d    = state_q;
    w_en_d     = w_en_q;
    w_addr_d   = w_addr_q;
    w_data_d   = w_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    offset_d   = offset_q;
    sel_d      = sel_q;
    color_d    = color_q;
    fill_off_d = fill_off_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Address 0 is issued on the accepting edge, so it uses the raw inputs.
          state_d    = S_WRITE;
          sel_d      = pattern_sel;
          color_d    = solid_color;
          fill_off_d = offset_q;
          w_en_d     = 1'b1;
          busy_d     = 1'b1;
          w_addr_d   = '0;
          w_data_d   = pattern_word(pattern_sel, solid_color, '0, offset_q);
        end
      end
      S_WRITE: begin
        if (&w_addr_q) begin
          state_d = S_DONE;
          w_en_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          w_addr_d = w_addr_q + ADDR_ONE;
          w_data_d = pattern_word(sel_q, color_q, w_addr_q + ADDR_ONE, fill_off_q);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        offset_d = offset_q + STEP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q    <= S_IDLE;
      w_en_q     <= 1'b0;
      w_addr_q   <= '0;
      w_data_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      offset_q   <= '0;
      sel_q      <= '0;
      color_q    <= '0;
      fill_off_q <= '0;
    end else begin
      state_q    <= state_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      offset_q   <= offset_d;
      sel_q      <= sel_d;
      color_q    <= color_d;
      fill_off_q <= fill_off_d;
    end
  end

  assign w_en         = w_en_q;
  assign w_addr       = w_addr_q;
  assign w_data       = w_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign frame_offset = offset_q;
  assign dbg_state    = state_q;

endmodule
